uart_baud_gen: RTL and testbench

//  Parametrised oversampling baud tick generator for the UART cores.
//  - Divides clk to a baud_tick strobe at OVERSAMPLE x baud.
//  - Fine-tunes the rate with a FRAC_WIDTH-bit fractional accumulator.
//  - Emits xmit_pulse once every OVERSAMPLE ticks for the transmitter.
//  - Adds glitch-free rate reload, an enable gate, and phase resync for the receiver start bit.

---
 rtl/uart_baud_gen_if.sv | 28 ++
 rtl/uart_baud_gen.sv | 76 +++++++
 tb/tb_uart_baud_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// Control and strobe bundle between a UART core and its baud tick generator.
// The core drives rate/enable/resync (master); the generator returns the strobes (slave).
interface uart_baud_gen_if #(
  parameter int CNT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 3,
  parameter int OVERSAMPLE = 16
);
  localparam int PH_W = $clog2(OVERSAMPLE);

  logic                  enable;
  logic                  load;
  logic [CNT_WIDTH-1:0]  baud_val;
  logic [FRAC_WIDTH-1:0] baud_frac;
  logic                  resync;
  logic                  baud_tick;
  logic                  xmit_pulse;
  logic [PH_W-1:0]       tick_phase;

  modport master (
    output enable, load, baud_val, baud_frac, resync,
    input  baud_tick, xmit_pulse, tick_phase
  );

  modport slave (
    input  enable, load, baud_val, baud_frac, resync,
    output baud_tick, xmit_pulse, tick_phase
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Oversampling baud tick generator: integer down-counter plus a fractional
// accumulator whose carry stretches a period by one clk.
module uart_baud_gen #(
  parameter int CNT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 3,
  parameter int OVERSAMPLE = 16
) (
  input logic            clk,
  input logic            reset_n,
  uart_baud_gen_if.slave bus
);
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  logic [CNT_WIDTH-1:0]  val_sh;
  logic [CNT_WIDTH-1:0]  val_next;
  logic [CNT_WIDTH-1:0]  cntr;
  logic [FRAC_WIDTH-1:0] frac_sh;
  logic [FRAC_WIDTH-1:0] acc;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  stretch;
  logic                  tick;
  logic                  xmit;
  logic [PH_W-1:0]       phase;

  // Wraps at OVERSAMPLE-1 so non-power-of-two oversampling works.
  function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] cur);
    return (cur == PH_LAST) ? '0 : cur + 1'b1;
  endfunction

  // A restart takes the rate being loaded in the same cycle.
  assign val_next = bus.load ? bus.baud_val : val_sh;
  assign acc_sum  = {1'b0, acc} + {1'b0, frac_sh};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_sh  <= '0;
      frac_sh <= '0;
      cntr    <= '0;
      acc     <= '0;
      stretch <= 1'b0;
      phase   <= '0;
      tick    <= 1'b0;
      xmit    <= 1'b0;
    end else begin
      tick <= 1'b0;
      xmit <= 1'b0;
      if (bus.load) begin
        val_sh  <= bus.baud_val;
        frac_sh <= bus.baud_frac;
      end
      if (!bus.enable || bus.resync) begin
        cntr    <= val_next;
        acc     <= '0;
        stretch <= 1'b0;
        phase   <= '0;
      end else if (cntr != '0) begin
        cntr <= cntr - 1'b1;
      end else if (stretch) begin
        stretch <= 1'b0;
      end else begin
        // Terminal count: reload from the shadow so a mid-period load waits its turn.
        tick    <= 1'b1;
        cntr    <= val_sh;
        acc     <= acc_sum[FRAC_WIDTH-1:0];
        stretch <= acc_sum[FRAC_WIDTH];
        phase   <= next_phase(phase);
        xmit    <= (phase == PH_LAST);
      end
    end
  end

  assign bus.baud_tick  = tick;
  assign bus.xmit_pulse = xmit;
  assign bus.tick_phase = phase;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: stimulus queues the expected tick cycles,
// a negedge monitor pops and compares whenever baud_tick is presented.
module tb_uart_baud_gen;
  localparam int CW = 16;
  localparam int FW = 3;
  localparam int OS = 16;

  typedef struct {
    int cyc;
    int phase;
    int xmit;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_phase = 0;
  exp_t sb[$];

  uart_baud_gen_if #(.CNT_WIDTH(CW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS)) dif ();

  uart_baud_gen #(.CNT_WIDTH(CW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int t);
    exp_t e;
    exp_phase = (exp_phase == OS - 1) ? 0 : exp_phase + 1;
    e.cyc   = t;
    e.phase = exp_phase;
    e.xmit  = (exp_phase == 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  // Monitor: every presented tick must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && dif.baud_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", cyc, -1);
      end else begin
        e = sb.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_phase", int'(dif.tick_phase), e.phase);
        check("xmit_pulse", int'(dif.xmit_pulse), e.xmit);
      end
    end else if (reset_n && dif.xmit_pulse) begin
      check("xmit_without_tick", 1, 0);
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_tick"}, int'(dif.baud_tick), 0);
    check({tag, "_xmit"}, int'(dif.xmit_pulse), 0);
    check({tag, "_phase"}, int'(dif.tick_phase), 0);
    check({tag, "_missing_ticks"}, sb.size(), 0);
    sb.delete();
    exp_phase = 0;
  endtask

  task automatic stop(input string tag);
    dif.enable = 1'b0;
    @(negedge clk);
    idle_check(tag);
  endtask

  task automatic start(input int val, input int frac);
    logic [CW-1:0] v;
    logic [FW-1:0] f;
    v = val[CW-1:0];
    f = frac[FW-1:0];
    @(negedge clk);
    dif.enable    = 1'b0;
    dif.load      = 1'b1;
    dif.baud_val  = v;
    dif.baud_frac = f;
    @(negedge clk);
    dif.load   = 1'b0;
    dif.enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int t;
    int r;
    reset_n       = 1'b0;
    dif.enable    = 1'b0;
    dif.load      = 1'b0;
    dif.resync    = 1'b0;
    dif.baud_val  = '0;
    dif.baud_frac = '0;
    repeat (3) @(negedge clk);
    check("reset_tick", int'(dif.baud_tick), 0);
    check("reset_xmit", int'(dif.xmit_pulse), 0);
    check("reset_phase", int'(dif.tick_phase), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: val=3 frac=0 -> tick every 4 clk, xmit on the 16th tick
    start(3, 0);
    s = cyc;
    for (int k = 1; k <= 20; k++) push_tick(s + 4 * k);
    wait_until(s + 80);
    stop("t1_stop");

    // T2: val=3 frac=4 -> periods 4,5,4,5...; tick1 to tick17 spans 72 clk
    start(3, 4);
    s = cyc;
    t = s + 4;
    push_tick(t);
    for (int k = 1; k < 17; k++) begin
      t += (k % 2 == 1) ? 4 : 5;
      push_tick(t);
    end
    wait_until(t);
    stop("t2_stop");

    // T3: load val=9 two clk into a period; that period still ends at 4 clk
    start(3, 0);
    s = cyc;
    push_tick(s + 4);
    push_tick(s + 8);
    push_tick(s + 12);
    push_tick(s + 22);
    push_tick(s + 32);
    push_tick(s + 42);
    wait_until(s + 9);
    dif.load      = 1'b1;
    dif.baud_val  = 16'd9;
    dif.baud_frac = 3'd0;
    @(negedge clk);
    dif.load = 1'b0;
    wait_until(s + 42);
    stop("t3_stop");

    // T4: resync at tick_phase 7, mid-count
    start(3, 0);
    s = cyc;
    for (int k = 1; k <= 7; k++) push_tick(s + 4 * k);
    wait_until(s + 29);
    dif.resync = 1'b1;
    @(negedge clk);
    dif.resync = 1'b0;
    check("t4_resync_tick", int'(dif.baud_tick), 0);
    check("t4_resync_phase", int'(dif.tick_phase), 0);
    exp_phase = 0;
    for (int j = 1; j <= 16; j++) push_tick(s + 34 + 4 * (j - 1));
    wait_until(s + 94);
    stop("t4_stop");

    // T5: val=0 frac=7 -> 8 ticks per 15 clk, then a 1-clk enable drop
    start(0, 7);
    s = cyc;
    t = s + 1;
    push_tick(t);
    for (int k = 1; k < 17; k++) begin
      t += (k % 8 == 1) ? 1 : 2;
      push_tick(t);
    end
    wait_until(t);
    dif.enable = 1'b0;
    @(negedge clk);
    idle_check("t5_gap");
    dif.enable = 1'b1;
    s = cyc;
    t = s + 1;
    push_tick(t);
    for (int k = 1; k < 8; k++) begin
      t += (k % 8 == 1) ? 1 : 2;
      push_tick(t);
    end
    wait_until(t);
    stop("t5_stop");

    // T6: async reset while a tick is showing; afterwards val_sh=0 ticks every clk
    start(9, 0);
    s = cyc;
    push_tick(s + 10);
    wait_until(s + 10);
    #1 reset_n = 1'b0;
    #1;
    check("t6_async_tick", int'(dif.baud_tick), 0);
    check("t6_async_xmit", int'(dif.xmit_pulse), 0);
    check("t6_async_phase", int'(dif.tick_phase), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    r = cyc;
    exp_phase = 0;
    for (int j = 1; j <= 20; j++) push_tick(r + j);
    wait_until(r + 20);
    stop("t6_stop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
